job_scheduler: RTL and testbench

//   Shares one go/kill/done job engine (the 100-count engine FSM) among NREQ requesters.

---
 rtl/job_scheduler_pkg.sv | 17 +
 rtl/job_scheduler_rr_arbiter.sv | 30 +++
 rtl/job_scheduler.sv | 131 +++++++++++++
 tb/tb_job_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/job_scheduler_pkg.sv
// Shared types and default parameters for the job scheduler.
package job_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    RUN     = 3'd2,
    KILL    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_TMO_W     = 8;
  localparam int DEF_TIMEOUT   = 120;
  localparam int DEF_KILL_HOLD = 2;

endpackage

// File: rtl/job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after the
// pointer, wrapping around, so the last owner gets lowest priority.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_pick,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = IDX_W'((int'(i_ptr) + i) % NREQ);
      if (i_req[w_idx]) begin
        o_pick        = '0;
        o_pick[w_idx] = 1'b1;
        o_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/job_scheduler.sv
// Shares one go/kill/done engine among NREQ requesters with round-robin
// arbitration, a watchdog on the RUN phase and owner cancel.
//
//   state   | meaning
//   IDLE    | engine free, waiting for any request
//   ISSUE   | owner latched, one-cycle go pulse to the engine
//   RUN     | job in flight, watchdog counting
//   KILL    | eng_kill held for KILL_HOLD cycles
//   RELEASE | grant dropped, cmpl/abrt pulse, pointer moves to owner
module job_scheduler
  import job_scheduler_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int TMO_W     = DEF_TMO_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int KILL_HOLD = DEF_KILL_HOLD
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_cancel,
  output logic [NREQ-1:0] o_grant,
  output logic [NREQ-1:0] o_cmpl,
  output logic [NREQ-1:0] o_abrt,
  output logic            o_eng_go,
  output logic            o_eng_kill,
  input  logic            i_eng_done,
  output logic            o_busy,
  output logic            o_err
);

  localparam int               IDX_W     = $clog2(NREQ);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] KILL_LAST = TMO_W'(KILL_HOLD - 1);
  localparam logic [TMO_W-1:0] TMO_SAT   = {TMO_W{1'b1}};

  state_t           r_state;
  state_t           w_next;
  logic [TMO_W-1:0] r_timer;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_pick_idx;
  logic [NREQ-1:0]  w_pick;
  logic [NREQ-1:0]  w_owner_oh;
  logic [NREQ-1:0]  r_cmpl;
  logic [NREQ-1:0]  r_abrt;
  logic             w_valid;
  logic             r_err;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_arb (
    .i_req  (i_req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_valid(w_valid)
  );

  // One-hot pick from the arbiter folded to an owner index.
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) w_pick_idx = IDX_W'(i);
    end
  end

  assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; done in RUN outranks cancel and timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_next = ISSUE;
      ISSUE:   w_next = RUN;
      RUN: begin
        if (i_eng_done)                                   w_next = RELEASE;
        else if (i_cancel[r_owner] || r_timer == TMO_LAST) w_next = KILL;
      end
      KILL:    if (r_timer == KILL_LAST) w_next = RELEASE;
      RELEASE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Owner, pointer, shared watchdog/kill timer, result pulses and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timer <= '0;
      r_owner <= '0;
      r_ptr   <= IDX_W'(NREQ - 1);
      r_cmpl  <= '0;
      r_abrt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_cmpl <= '0;
      r_abrt <= '0;
      if (i_eng_done && r_state != RUN) r_err <= 1'b1;
      case (r_state)
        IDLE:  if (w_valid) r_owner <= w_pick_idx;
        ISSUE: r_timer <= '0;
        RUN: begin
          if (w_next == KILL)         r_timer <= '0;
          else if (r_timer != TMO_SAT) r_timer <= r_timer + 1'b1;
          if (w_next == RELEASE) r_cmpl <= w_owner_oh;
        end
        KILL: begin
          if (w_next == RELEASE)       r_abrt  <= w_owner_oh;
          else if (r_timer != TMO_SAT) r_timer <= r_timer + 1'b1;
        end
        RELEASE: r_ptr <= r_owner;
        default: ;
      endcase
    end
  end

  assign o_grant    = (r_state == ISSUE || r_state == RUN || r_state == KILL) ? w_owner_oh : '0;
  assign o_eng_go   = (r_state == ISSUE);
  assign o_eng_kill = (r_state == KILL);
  assign o_busy     = (r_state != IDLE);
  assign o_cmpl     = r_cmpl;
  assign o_abrt     = r_abrt;
  assign o_err      = r_err;

endmodule

// File: tb/tb_job_scheduler.sv
// Bench for job_scheduler: every cycle is compared against a job-level
// reference model; a table of arbitration vectors plus hand-written
// sequences cover latency, timeout, cancel, done/cancel race, stray done
// and mid-job reset, followed by a randomized run.
module tb_job_scheduler;

  localparam int NREQ      = 4;
  localparam int TMO_W     = 8;
  localparam int TIMEOUT   = 120;
  localparam int KILL_HOLD = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, cancel;
  logic       eng_done;
  logic [3:0] grant, cmpl, abrt;
  logic       eng_go, eng_kill, busy, err;

  always #5 clk = ~clk;

  job_scheduler #(
    .NREQ(NREQ), .TMO_W(TMO_W), .TIMEOUT(TIMEOUT), .KILL_HOLD(KILL_HOLD)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_cancel(cancel),
    .o_grant(grant), .o_cmpl(cmpl), .o_abrt(abrt),
    .o_eng_go(eng_go), .o_eng_kill(eng_kill), .i_eng_done(eng_done),
    .o_busy(busy), .o_err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [3:0] v, input int k);
    return ((v >> k) & 4'b0001) != 4'b0000;
  endfunction

  // Next requester after p (wrapping) that is asking; -1 if none.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    int pick;
    pick = -1;
    for (int i = NREQ; i >= 1; i--)
      if (bit_of(r, (p + i) % NREQ)) pick = (p + i) % NREQ;
    return pick;
  endfunction

  // Reference model: one job record (owner, cycles since go, remaining kill
  // cycles, release bubble) advanced once per clock from the sampled inputs.
  int         m_owner = -1;
  int         m_ptr   = NREQ - 1;
  int         m_age   = 0;
  int         m_kill  = 0;
  bit         m_rel   = 1'b0;
  bit         m_err   = 1'b0;
  logic [3:0] m_cmpl  = '0;
  logic [3:0] m_abrt  = '0;

  task automatic m_step();
    bit running;
    m_cmpl = '0;
    m_abrt = '0;
    if (reset) begin
      m_owner = -1; m_ptr = NREQ - 1; m_age = 0; m_kill = 0; m_rel = 1'b0; m_err = 1'b0;
    end else begin
      running = (m_owner >= 0) && !m_rel && (m_kill == 0) && (m_age >= 1);
      if (eng_done && !running) m_err = 1'b1;
      if (m_owner < 0) begin
        if (req != 4'b0000) begin
          m_owner = rr_pick(req, m_ptr); m_age = 0; m_kill = 0; m_rel = 1'b0;
        end
      end else if (m_rel) begin
        m_ptr = m_owner; m_owner = -1; m_rel = 1'b0;
      end else if (m_kill > 0) begin
        m_kill--;
        if (m_kill == 0) begin
          m_rel = 1'b1; m_abrt = 4'b0001 << m_owner;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (eng_done) begin
        m_rel = 1'b1; m_cmpl = 4'b0001 << m_owner;
      end else begin
        // age counts RUN cycles already spent; TIMEOUT of them trigger the kill
        if (bit_of(cancel, m_owner) || m_age == TIMEOUT) m_kill = KILL_HOLD;
        m_age++;
      end
    end
  endtask

  // Engine stand-in: done eng_delay cycles after go, forgotten on kill/reset.
  bit eng_auto  = 1'b1;
  int eng_delay = 102;
  int eng_cnt   = 0;

  task automatic tick();
    logic [3:0] e_grant;
    @(posedge clk);
    m_step();
    @(negedge clk);
    e_grant = '0;
    if (m_owner >= 0 && !m_rel) e_grant = 4'b0001 << m_owner;
    chk("grant", grant, e_grant);
    chk("eng_go", eng_go, (m_owner >= 0 && !m_rel && m_kill == 0 && m_age == 0));
    chk("eng_kill", eng_kill, (m_kill > 0));
    chk("busy", busy, (m_owner >= 0));
    chk("cmpl", cmpl, m_cmpl);
    chk("abrt", abrt, m_abrt);
    chk("err", err, m_err);
    if (eng_auto) begin
      if (reset || eng_kill) eng_cnt = 0;
      else if (eng_go)       eng_cnt = eng_delay;
      else if (eng_cnt > 0)  eng_cnt--;
      eng_done = (eng_cnt == 1);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_grant(input string name, input logic [3:0] exp, input int budget);
    int k;
    k = 0;
    while (grant == 4'b0000 && k < budget) begin
      tick(); k++;
    end
    chk(name, grant, exp);
  endtask

  // Runs the current job out; the owner drops req once grant falls.
  task automatic finish_job(input string name, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick(); k++;
      if (grant == 4'b0000) req = 4'b0000;
    end
    chk(name, busy, 1'b0);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
  } arb_vec_t;

  arb_vec_t   tbl[10];
  logic [3:0] seq[5];
  logic [3:0] exp_seq[5];
  logic [3:0] prev;
  int         got, k;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got busy=%0b expected finish", busy);
    $fatal(1, "watchdog");
  end

  initial begin
    // pointer sequence continues from owner 0 left by the single-request job
    tbl[0] = '{4'b1111, 4'b0010};
    tbl[1] = '{4'b1111, 4'b0100};
    tbl[2] = '{4'b1111, 4'b1000};
    tbl[3] = '{4'b1111, 4'b0001};
    tbl[4] = '{4'b1001, 4'b1000};
    tbl[5] = '{4'b0110, 4'b0010};
    tbl[6] = '{4'b0010, 4'b0010};
    tbl[7] = '{4'b0101, 4'b0100};
    tbl[8] = '{4'b0011, 4'b0001};
    tbl[9] = '{4'b1100, 4'b0100};
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0010;
    exp_seq[3] = 4'b0100; exp_seq[4] = 4'b1000;

    reset = 1'b1; req = '0; cancel = '0; eng_done = 1'b0;
    ticks(3);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;
    tick();

    // single request: go one cycle after req, completion, back to idle
    req = 4'b0001;
    tick();
    chk("t1_go_latency", eng_go, 1'b1);
    chk("t1_grant", grant, 4'b0001);
    got = 0; k = 0;
    while (busy && k < 200) begin
      tick(); k++;
      if (cmpl == 4'b0001) got++;
      if (grant == 4'b0000) req = 4'b0000;
    end
    chk("t1_cmpl_once", got, 1);
    chk("t1_idle", busy, 1'b0);

    // arbitration table with short jobs
    eng_delay = 3;
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req;
      wait_grant($sformatf("tbl%0d_grant", i), tbl[i].exp_grant, 10);
      finish_job($sformatf("tbl%0d_idle", i), 50);
    end

    // continuous 1111: rotating grants
    req = 4'b1111; got = 0; prev = '0;
    for (int j = 0; j < 200 && got < 5; j++) begin
      tick();
      if (grant != 4'b0000 && prev == 4'b0000) begin
        seq[got] = grant; got++;
      end
      prev = grant;
    end
    finish_job("t2_idle", 50);
    chk("t2_count", got, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), seq[i], exp_seq[i]);

    // watchdog: engine never answers
    eng_auto = 1'b0; eng_done = 1'b0;
    req = 4'b0010;
    tick();
    chk("t3_go", eng_go, 1'b1);
    k = 0;
    while (!eng_kill && k < 300) begin
      tick(); k++;
    end
    chk("t3_kill_delay", k, TIMEOUT + 1);
    k = 0;
    while (eng_kill && k < 10) begin
      tick(); k++;
    end
    chk("t3_kill_len", k, KILL_HOLD);
    chk("t3_abrt", abrt, 4'b0010);
    chk("t3_err", err, 1'b0);
    finish_job("t3_idle", 10);

    // cancel: non-owner ignored, owner kills on the next cycle
    req = 4'b0100;
    tick();
    ticks(5);
    cancel = 4'b1000;
    tick();
    cancel = 4'b0000;
    chk("t4_nonowner_ignored", eng_kill, 1'b0);
    ticks(5);
    cancel = 4'b1100;
    tick();
    cancel = 4'b0000;
    chk("t4_kill_next", eng_kill, 1'b1);
    ticks(2);
    chk("t4_abrt", abrt, 4'b0100);
    chk("t4_no_cmpl", cmpl, 4'b0000);
    finish_job("t4_idle", 10);

    // done and owner cancel together: done wins
    req = 4'b1000;
    tick();
    ticks(3);
    eng_done = 1'b1; cancel = 4'b1000;
    tick();
    eng_done = 1'b0; cancel = 4'b0000;
    chk("t5_cmpl", cmpl, 4'b1000);
    chk("t5_abrt", abrt, 4'b0000);
    finish_job("t5_idle", 10);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("t5_err_set", err, 1'b1);
    ticks(5);
    chk("t5_err_sticky", err, 1'b1);

    // reset during RUN
    eng_auto = 1'b1; eng_delay = 102;
    req = 4'b0100;
    tick();
    ticks(5);
    reset = 1'b1;
    tick();
    chk("t6_grant", grant, 4'b0000);
    chk("t6_kill", eng_kill, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_err_clr", err, 1'b0);
    reset = 1'b0; req = 4'b1111; eng_delay = 3;
    wait_grant("t6_ptr_reset", 4'b0001, 10);
    finish_job("t6_idle_a", 50);
    req = 4'b1000;
    wait_grant("t6_req3", 4'b1000, 10);
    finish_job("t6_idle_b", 50);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (!busy) eng_delay = $urandom_range(1, 140);
      tick();
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      cancel = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      if ($urandom_range(0, 499) == 0) eng_done = 1'b1;
      reset = ($urandom_range(0, 799) == 0);
    end
    reset = 1'b0; req = '0; cancel = '0;
    ticks(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
